// File: rtl/ex3_2_pkg.sv
// Shared constants and the golden (a + b) mod 2^WIDTH function for the ex3_2 adder.
package ex3_2_pkg;

  localparam int WIDTH_DEFAULT = 3;

  // Golden modular sum. The gate-level datapath in the core does not use it.
  function automatic logic [WIDTH_DEFAULT-1:0] ref_add(
    input logic [WIDTH_DEFAULT-1:0] a,
    input logic [WIDTH_DEFAULT-1:0] b
  );
    logic [WIDTH_DEFAULT:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[WIDTH_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/ex3_2_fa.sv
// 1-bit full adder made only of and/or/xor, so it maps one-to-one onto the BDD flow.
module ex3_2_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g;
  logic t;

  // Propagate, generate and carry-through terms.
  assign p  = a ^ b;
  assign g  = a & b;
  assign t  = ci & p;
  assign s  = p ^ ci;
  assign co = g | t;

endmodule

// File: rtl/ex3_2_core.sv
// Modular adder with a registered output: y = (a + b) mod 2^WIDTH, one cycle of latency.
// There is no handshake: a and b are sampled on every rising edge and a new
// result appears one edge later.
module ex3_2_core
  import ex3_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             carry_out_unused;

  // The ripple chain starts with no carry in.
  assign carry[0] = 1'b0;

  // The final carry is dropped on purpose, so an overflow wraps silently.
  assign carry_out_unused = carry[WIDTH];

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_fa
    ex3_2_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Output register. Reset takes priority over the new sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= sum;
    end
  end

endmodule

// File: tb/tb_ex3_2_core.sv
// Directed bench for ex3_2_core: reset, exhaustive sweep with a reset in the middle,
// wrap-around, latency and hold scenarios.
module tb_ex3_2_core;
  import ex3_2_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] a;
  logic [2:0] b;
  logic [2:0] y;

  int n_cmp = 0;
  int n_err = 0;

  ex3_2_core #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .y   (y)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector, let a rising edge sample it, then wait #1 so the
  // checks that follow see the registered result away from the edge.
  task automatic cycle(input logic [2:0] ia, input logic [2:0] ib, input logic irst);
    a   = ia;
    b   = ib;
    rst = irst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(3'd5, 3'd3, 1'b1);
      n_cmp++;
      if (y !== 3'd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: y=%0d expected 0", k, y);
      end
    end
    // The first edge after release samples 5 + 3, which wraps to 0.
    cycle(3'd5, 3'd3, 1'b0);
    n_cmp++;
    if (y !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release: y=%0d expected 0", y);
    end
    cycle(3'd5, 3'd3, 1'b0);
    n_cmp++;
    if (y !== 3'd0) begin
      n_err++;
      $display("FAIL reset_first_sum: y=%0d expected 0", y);
    end
  endtask

  task automatic test_examples();
    logic [2:0] va [3];
    logic [2:0] vb [3];
    logic [2:0] ve [3];
    va = '{3'd0, 3'd2, 3'd3};
    vb = '{3'd1, 3'd5, 3'd6};
    ve = '{3'd1, 3'd7, 3'd1};
    for (int k = 0; k < 3; k++) begin
      cycle(va[k], vb[k], 1'b0);
      n_cmp++;
      if (y !== ve[k]) begin
        n_err++;
        $display("FAIL example %0d+%0d: y=%0d expected %0d", va[k], vb[k], y, ve[k]);
      end
    end
  endtask

  // All 64 operand pairs, with a single-cycle reset in place of the 6 + 3 vector.
  // Before each edge the output must still show the previous result.
  task automatic test_sweep();
    logic [2:0] prev_exp;
    logic [2:0] exp_y;
    logic       do_rst;
    prev_exp = y;
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        do_rst = (ia == 6 && ib == 3);
        a   = 3'(ia);
        b   = 3'(ib);
        rst = do_rst;
        #1;
        n_cmp++;
        if (y !== prev_exp) begin
          n_err++;
          $display("FAIL sweep_hold_before_edge %0d+%0d: y=%0d expected %0d", ia, ib, y, prev_exp);
        end
        @(posedge clk);
        #1;
        exp_y = do_rst ? 3'd0 : ref_add(3'(ia), 3'(ib));
        n_cmp++;
        if (y !== exp_y) begin
          n_err++;
          $display("FAIL sweep %0d+%0d rst=%0b: y=%0d expected %0d", ia, ib, do_rst, y, exp_y);
        end
        prev_exp = exp_y;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0] va [3];
    logic [2:0] vb [3];
    logic [2:0] ve [3];
    va = '{3'd7, 3'd7, 3'd4};
    vb = '{3'd1, 3'd7, 3'd4};
    ve = '{3'd0, 3'd6, 3'd0};
    for (int k = 0; k < 3; k++) begin
      cycle(va[k], vb[k], 1'b0);
      n_cmp++;
      if (y !== ve[k]) begin
        n_err++;
        $display("FAIL wrap %0d+%0d: y=%0d expected %0d", va[k], vb[k], y, ve[k]);
      end
    end
  endtask

  task automatic test_latency();
    cycle(3'd1, 3'd1, 1'b0);
    n_cmp++;
    if (y !== 3'd2) begin
      n_err++;
      $display("FAIL latency_first: y=%0d expected 2", y);
    end
    // New operands present mid-cycle must not reach y before the next edge.
    a = 3'd6;
    b = 3'd0;
    #2;
    n_cmp++;
    if (y !== 3'd2) begin
      n_err++;
      $display("FAIL latency_mid_cycle: y=%0d expected 2", y);
    end
    cycle(3'd6, 3'd0, 1'b0);
    n_cmp++;
    if (y !== 3'd6) begin
      n_err++;
      $display("FAIL latency_second: y=%0d expected 6", y);
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 5; k++) begin
      cycle(3'd3, 3'd2, 1'b0);
      n_cmp++;
      if (y !== 3'd5) begin
        n_err++;
        $display("FAIL hold_edge[%0d]: y=%0d expected 5", k, y);
      end
      #3;
      n_cmp++;
      if (y !== 3'd5) begin
        n_err++;
        $display("FAIL hold_mid[%0d]: y=%0d expected 5", k, y);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = 3'd5;
    b   = 3'd3;
    test_reset();
    test_examples();
    test_sweep();
    test_wrap();
    test_latency();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex3_2_core.md
Name: ex3_2_core

Overview:
- 3-bit modular adder with a registered output: y = (a + b) mod 2^WIDTH.
- Leaf arithmetic block in the gate-level netlist test suite, used as an ECO/BDD equivalence target.
- Datapath is built structurally from a ripple chain of full-adder cells, so the netlist maps gate-for-gate onto the BDD flow.
- The result is captured in one output register.

Parameters:
- WIDTH, 3, operand and result width in bits; the bench sweeps only 3.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- y  output  WIDTH  registered sum (a + b) mod 2^WIDTH, unsigned.

Behaviour:
- Combinational sum: s[i] = a[i] ^ b[i] ^ c[i].
- Carry chain: c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])), with c[0] = 0.
- The final carry c[WIDTH] is discarded. Overflow wraps silently, e.g. 7 + 1 -> 0 and 7 + 7 -> 6.
- Latency: y at rising edge k+1 equals the sum of the a and b values sampled at edge k. Exactly 1 cycle; no bubbles, no handshake. A new result is produced every cycle.
- Reset: if rst = 1 at a rising edge, y <= 0 regardless of a and b. This takes priority over the sum.
- First valid sum after reset: rst deasserted at edge k, operands present at edge k+1, result visible after edge k+1.
- Reset mid-stream: the in-flight result is lost; y = 0 for every cycle rst is held high.
- No other state. No X-propagation masking is required; inputs are assumed driven.
- Operands held constant give a constant y after 1 cycle. Changing only b every cycle gives y tracking a + b with a 1-cycle delay.
- Inputs are sampled only at rising edges; glitches between edges have no effect.

Decomposition:
- Shared package ex3_2_pkg: constant WIDTH_DEFAULT = 3.
- Shared package ex3_2_pkg: function ref_add(a, b) returning (a + b) mod 2^WIDTH. The verification model uses this function; the RTL datapath does not.
- Sub-module ex3_2_fa: 1-bit full adder (inputs a, b, ci; outputs s, co), built from and/or/xor primitives.
  - WIDTH instances are chained in a generate loop.
- Top level contents: the chain, the WIDTH-bit output register with synchronous reset, and port glue.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with a = 5, b = 3 -> y = 0 on both cycles. Release rst -> y = 0 the next cycle, then y = 0 again after the following edge (5 + 3 = 8 wraps to 0).
- Exhaustive sweep: a = 0..7 outer loop, b = 0..7 inner loop, one vector per cycle (64 vectors) -> each y equals (a + b) mod 8 one cycle after application. For example a = 0, b = 1 -> 1; a = 2, b = 5 -> 7; a = 3, b = 6 -> 1.
- Wrap-around: a = 7, b = 1 -> y = 0; a = 7, b = 7 -> y = 6; a = 4, b = 4 -> y = 0.
- Latency check: a = 1, b = 1 at edge k, then a = 6, b = 0 at edge k+1 -> y = 2 after edge k+1 and y = 6 after edge k+2.
- Mid-stream reset: during the sweep at a = 6, b = 3, assert rst for 1 cycle -> y = 0 that cycle. The next vector a = 6, b = 4 yields y = 2.
- Hold: a = 3, b = 2 held for 5 cycles -> y = 5 steady from cycle 2 on, with no toggling.
